// File: rtl/t5_dmem.sv
// t5 data-memory bus initiator: one outstanding Wishbone-style cycle with lane steering and pipeline stall.
// Optional misaligned-access trap enabled by defining T5_MISALIGN_TRAP_EN (adds the dmis port).
module t5_dmem #(
   parameter int unsigned XLEN = 32
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic            sena,
   input  logic [6:2]      xopc,
   input  logic [14:12]    xfn3,
   input  logic [XLEN-1:0] xadr,
   input  logic [XLEN-1:0] xdat,
   input  logic            dwb_ack,
   output logic [XLEN-1:0] dwb_adr,
   output logic [XLEN-1:0] dwb_dto,
   output logic [3:0]      dwb_sel,
   output logic            dwb_stb,
   output logic            dwb_wre,
   output logic            dstall
`ifdef T5_MISALIGN_TRAP_EN
   ,
   output logic            dmis
`endif
);

   localparam logic [4:0] OPC_LOAD  = 5'b00000;
   localparam logic [4:0] OPC_STORE = 5'b01000;
   localparam logic [1:0] SZ_BYTE   = 2'b00;
   localparam logic [1:0] SZ_HALF   = 2'b01;
   localparam int unsigned NBYTE    = XLEN / 8;
   localparam int unsigned NHALF    = XLEN / 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   adr_q, adr_d;
   logic [XLEN-1:0]   dto_q, dto_d;
   logic [3:0]        sel_q, sel_d;
   logic              stb_q, stb_d;
   logic              wre_q, wre_d;

   logic              is_load, is_store, mem_op;
   logic              slot_free, misal, req_take;
   logic [1:0]        size;
   logic [3:0]        lane_sel;
   logic [XLEN-1:0]   lane_dat;

   // funct3[14] (sign/zero-extend) only matters to the write-back stage
   logic              unused_fn3;
   assign unused_fn3 = xfn3[14];

   assign size      = xfn3[13:12];
   assign is_load   = (xopc == OPC_LOAD);
   assign is_store  = (xopc == OPC_STORE);
   assign mem_op    = is_load | is_store;
   // a new cycle may start when idle or on the edge the current one is acknowledged
   assign slot_free = (state_q == ST_IDLE) | dwb_ack;

`ifdef T5_MISALIGN_TRAP_EN
   assign misal = ((size == SZ_HALF) & xadr[0]) | (size[1] & (xadr[1:0] != 2'b00));
`else
   assign misal = 1'b0;
`endif

   assign req_take = sena & mem_op & slot_free & ~misal;

   // Byte-lane select and replicated store data by access size
   always_comb begin
      lane_sel = 4'hF;
      lane_dat = xdat;
      case (size)
         SZ_BYTE: begin
            lane_sel = 4'b0001 << xadr[1:0];
            lane_dat = {NBYTE{xdat[7:0]}};
         end
         SZ_HALF: begin
            lane_sel = xadr[1] ? 4'hC : 4'h3;
            lane_dat = {NHALF{xdat[15:0]}};
         end
         default: begin
            lane_sel = 4'hF;
            lane_dat = xdat;
         end
      endcase
   end

   // State register
   always_ff @(posedge sclk) begin
      if (srst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_take) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dwb_ack) begin
               state_d = req_take ? ST_WAIT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: stall is the only unregistered output
   always_comb begin
      dstall = 1'b0;
      if (state_q == ST_WAIT) begin
         dstall = ~dwb_ack;
      end
   end

   // Bus field next values: load on acceptance, otherwise hold
   always_comb begin
      adr_d = adr_q;
      dto_d = dto_q;
      sel_d = sel_q;
      wre_d = wre_q;
      stb_d = (state_q == ST_WAIT) & ~dwb_ack;
      if (req_take) begin
         adr_d = {xadr[XLEN-1:2], 2'b00};
         dto_d = lane_dat;
         sel_d = lane_sel;
         wre_d = is_store;
         stb_d = 1'b1;
      end
   end

   always_ff @(posedge sclk) begin
      if (srst) begin
         adr_q <= '0;
         dto_q <= '0;
         sel_q <= 4'h0;
         wre_q <= 1'b0;
         stb_q <= 1'b0;
      end else begin
         adr_q <= adr_d;
         dto_q <= dto_d;
         sel_q <= sel_d;
         wre_q <= wre_d;
         stb_q <= stb_d;
      end
   end

`ifdef T5_MISALIGN_TRAP_EN
   logic dmis_q, dmis_d;

   // One-cycle pulse for a misaligned request that would otherwise have been accepted
   assign dmis_d = sena & mem_op & slot_free & misal;

   always_ff @(posedge sclk) begin
      if (srst) begin
         dmis_q <= 1'b0;
      end else begin
         dmis_q <= dmis_d;
      end
   end

   assign dmis = dmis_q;
`endif

   assign dwb_adr = adr_q;
   assign dwb_dto = dto_q;
   assign dwb_sel = sel_q;
   assign dwb_stb = stb_q;
   assign dwb_wre = wre_q;

endmodule

// File: doc/t5_dmem.md
# t5_dmem

Data-memory bus initiator for the t5 core. Takes the load/store in the X stage and drives a single-outstanding Wishbone-style data bus cycle. It aligns store data onto byte lanes and generates lane selects. It also stalls the pipeline until the slave acknowledges. Its `dwb_sel` output feeds the write-back stage as `xsel`, which uses it to extract and extend load data from `dwb_dti` on the acknowledge edge.

## Interface
Parameters:
- `XLEN`, default 32, datapath and address width.

Ports:
- `sclk` in 1: core clock; everything is synchronous to its rising edge.
- `srst` in 1: synchronous, active-high reset.
- `sena` in 1: global pipeline enable; a new request is accepted only on an edge with `sena`=1.
- `xopc` in [6:2]: X-stage opcode. 5'b00000 is a load, 5'b01000 is a store, anything else is not a memory op.
- `xfn3` in [14:12]: X-stage funct3. [13:12] is the size (00 byte, 01 half, 10 word); [14] is ignored here.
- `xadr` in XLEN: X-stage effective address (ALU result).
- `xdat` in XLEN: X-stage store data (rs2).
- `dwb_ack` in 1: slave acknowledge.
- `dwb_adr` out XLEN: word-aligned bus address.
- `dwb_dto` out XLEN: store data, replicated across lanes.
- `dwb_sel` out 4: byte-lane select.
- `dwb_stb` out 1: cycle request.
- `dwb_wre` out 1: write enable (1 = store).
- `dstall` out 1: pipeline stall request.
- `dmis` out 1: misaligned-access pulse; only present when `T5_MISALIGN_TRAP_EN` is defined.

## Operation
- States: IDLE and WAIT.
- **Accepting a request:** a request is taken on an edge where `sena`=1 and `xopc` is a load or store, in IDLE or on the acknowledging edge in WAIT. On that edge:
  - `dwb_adr` <= {`xadr`[XLEN-1:2], 2'b00}
  - `dwb_wre` <= 1 for a store, 0 for a load
  - `dwb_stb` <= 1
  - state <= WAIT
- **Lane select and store data by size:**
  - byte: `dwb_sel` = 4'b0001 << `xadr`[1:0]; `dwb_dto` = {4{`xdat`[7:0]}}.
  - half: `dwb_sel` = `xadr`[1] ? 4'hC : 4'h3; `dwb_dto` = {2{`xdat`[15:0]}}.
  - word, or size 11: `dwb_sel` = 4'hF; `dwb_dto` = `xdat`.
  - Loads use the same `dwb_sel` encoding; `dwb_dto` is don't-care for loads but is still loaded with the aligned data.
- **While in WAIT:**
  - `dwb_adr`, `dwb_dto`, `dwb_sel` and `dwb_wre` are held stable.
  - `dwb_stb` stays at 1 until the edge on which `dwb_ack`=1 is sampled.
- **On the acknowledging edge:**
  - If a new request is accepted on the same edge, the next cycle is issued back-to-back: `dwb_stb` stays 1 and the new fields are loaded.
  - Otherwise `dwb_stb` <= 0 and state <= IDLE.
- **After a cycle completes:** `dwb_sel`, `dwb_adr` and `dwb_wre` keep their last values until the next request, so `xsel` stays defined for the write-back stage. `dwb_dto` is likewise held.
- **Stall:** `dstall` = (state==WAIT) & !`dwb_ack`, combinational. It drops in the acknowledge cycle so that `sena` rises and the write-back stage samples `dwb_dti` on that edge.
- **Ignored inputs:**
  - `dwb_ack` in IDLE.
  - A non-memory `xopc`, and any request while `sena`=0.
- Only one transaction is outstanding at a time; there is no pipelining of requests.

## Timing
- Reset values: `dwb_stb`=0, `dwb_wre`=0, `dwb_sel`=4'h0, `dwb_adr`=0, `dwb_dto`=0, `dmis`=0, state IDLE, hence `dstall`=0.
- A reset in WAIT aborts the cycle: `dwb_stb`=0 on the next edge and any later `dwb_ack` is ignored.
- `dwb_stb` rises one edge after acceptance.
- With a zero-wait slave (`dwb_ack` asserted in the first `dwb_stb` cycle), a transaction occupies exactly one bus cycle and `dstall` never asserts.
- Each wait cycle of the slave adds one cycle of `dstall`=1.
- Outputs are registered, except `dstall`.

## Configuration
- `T5_MISALIGN_TRAP_EN` defined: a half access with `xadr`[0]=1, or a word access with `xadr`[1:0]≠0, is not issued.
  - `dwb_stb` stays 0 and the state does not change.
  - `dmis` is a registered one-cycle pulse (1 on the edge after acceptance).
- `T5_MISALIGN_TRAP_EN` undefined: the `dmis` port is absent and misaligned accesses issue normally.
  - The offending low address bits are ignored by the `dwb_sel` encoding above: half at offset 1 gives 4'h3; word gives 4'hF.

## Test plan
- **Reset:** hold `srst` 2 cycles -> all outputs at their reset values; `dwb_ack`=1 in IDLE causes no change.
- **Store byte:** SB, `xadr`=0x1003, `xdat`=0x000000A5, `sena`=1, ack in the first cycle:
  - next edge: `dwb_adr`=0x1000, `dwb_sel`=4'h8, `dwb_dto`=0xA5A5A5A5, `dwb_wre`=1, `dwb_stb`=1, `dstall`=0.
  - the edge after: `dwb_stb`=0.
- **Load half with wait states:** LH, `xadr`=0x2002, ack after 3 cycles -> `dwb_sel`=4'hC, `dwb_wre`=0, `dstall`=1 for 2 cycles then 0 in the ack cycle; `dwb_stb` falls on the ack edge.
- **Back-to-back:** SW at 0x10, then LW at 0x14 accepted on the SW ack edge -> `dwb_stb` stays 1, `dwb_adr` becomes 0x14, `dwb_wre` 0, `dwb_sel` 4'hF.
- **Reset mid-cycle:** `srst` asserted in WAIT -> next edge `dwb_stb`=0 and state IDLE; a later `dwb_ack`=1 produces no change.
- **Misalignment with the macro defined:** LW, `xadr`=0x3001 -> `dmis`=1 for exactly one cycle, `dwb_stb` stays 0, `dstall`=0.
- **Misalignment with the macro undefined:** same stimulus -> `dwb_stb`=1, `dwb_adr`=0x3000, `dwb_sel`=4'hF.
